sd_card_spi_model: RTL and testbench
====================================

// Module: sd_card_spi_model
// PURPOSE
//  Parametrised SPI-mode SD card behavioural model for controller benches; successor to the fixed CMD0-only responder.
//  Oversamples SPI on clk, decodes 6-byte command frames and answers CMD0/8/55/ACMD41/58/17 with R1/R3/R7 responses.
//  Holds a block-addressed read-only memory that CMD17 streams out. Sits opposite the sdcard controller's SPI master.
// PARAMETERS
//  BLOCK_SIZE      512  bytes per data block (power of two, 16..512)
//  MEM_BLOCKS      4    number of addressable blocks (block-addressed, SDHC style)
//  NCR_BYTES       1    0xFF bytes between command end and response (1..8)
//  NAC_BYTES       2    0xFF bytes between R1 of CMD17 and data token (1..16)
//  ACMD41_RETRIES  2    ACMD41 answers returning 0x01 before 0x00 (0..15)
// PORTS
//  clk        in   1  system clock, >= 8x sclk frequency
//  rst        in   1  synchronous reset, active high
//  sclk       in   1  SPI clock from host (async, mode 0)
//  cs_n       in   1  chip select, active low (async)
//  mosi       in   1  host -> card data
//  miso       out  1  card -> host data
//  card_idle  out  1  R1 idle bit (1 until ACMD41 completes)
//  cmd_valid  out  1  one-clk pulse when a full command frame is accepted
//  cmd_index  out  6  index of last accepted command
// BEHAVIOUR
//  Reset: miso=1, card_idle=1, cmd_valid=0, cmd_index=0, FSM=IDLE, app flag=0, retry cnt=0.
//  sclk/cs_n/mosi pass 2-flop sync; edges from synced sclk. Rising edge: sample mosi MSB-first. Falling edge: drive next tx bit.
//  Byte done after 8th rising edge; tx byte loaded then, its MSB driven at next falling edge. cs_n high: bit count clears, miso=1, FSM->IDLE, card state kept.
//  FSM: IDLE (tx 0xFF; byte with [7:6]=01 starts frame) -> CMD_RX (5 more bytes) -> NCR (NCR_BYTES x 0xFF) -> RESP (R1 plus 0/4 trailing bytes)
//   -> IDLE, or for accepted CMD17 -> NAC (NAC_BYTES x 0xFF) -> TOKEN (0xFE) -> DATA (BLOCK_SIZE bytes) -> CRC (2 x 0xFF) -> IDLE.
//  mosi ignored outside IDLE/CMD_RX. cmd_valid pulses on 6th byte; cmd_index = byte0[5:0]; arg = bytes1..4 big-endian.
//  R1 = {0, param_err, 0, 0, crc_err, illegal, 0, card_idle}; illegal/param/crc bits are per-command, not sticky.
//  CMD0: card_idle<=1, app<=0, retry<=0; R1 0x01.  CMD8: R7 = R1 + 00 00 01 arg[7:0] (echo check pattern).
//  CMD55: R1, app<=1 for next command only.  ACMD41 (CMD41 with app=1): R1 0x01 while retry<ACMD41_RETRIES (retry++), else 0x00, card_idle<=0.
//  CMD41 without app, any other index: R1 illegal (0x04|idle).  CMD58: R3 = R1 + C0 FF 80 00.
//  CMD17: idle -> illegal (0x05); arg>=MEM_BLOCKS -> 0x40, no data; else R1 0x00 and block arg streamed.
//  Memory content: byte i of block b = (b*BLOCK_SIZE+i) mod 256, fixed at reset; data address counter width $clog2(BLOCK_SIZE).
//  Reset mid-transfer: abort immediately to reset values; host sees miso=1 from next falling edge.
// CONFIGURATION
//  SD_MODEL_CRC_CHECK_EN defined: byte5 must equal {CRC7(bytes0..4),1}; mismatch -> R1 crc_err (0x08|idle), command not executed, app cleared.
//  Undefined: byte5 ignored entirely; every well-formed frame executes.
// STRUCTURE
//  Package sd_model_pkg: command index constants (CMD0..CMD58), R1 bit positions, OCR value, data token, FSM state enum, crc7 function.
//  Sub-module sd_spi_byte_if: sync, edge detect, rx/tx shift, byte_done strobe, tx_load; the top holds FSM, card state, memory.
// TESTING
//  CMD0 40 00 00 00 00 95 -> after NCR 0xFF, R1 0x01; cmd_valid one pulse, cmd_index 0.
//  CMD8 arg 0x1AA -> 01 00 00 01 AA; CMD17 before init -> 0x05, no 0xFE token.
//  CMD55+ACMD41 x3 (RETRIES=2) -> 0x01, 0x01, 0x00; card_idle falls; CMD58 -> 00 C0 FF 80 00.
//  CMD17 arg 1 (BLOCK_SIZE=16) -> 00, 2x FF, FE, 10..1F, FF FF; arg 4 -> 0x40 only.
//  cs_n high mid-DATA, then CMD58 -> clean R3, card_idle stays 0; rst mid-DATA -> miso 1, card_idle 1.
//  SD_MODEL_CRC_CHECK_EN: CMD0 with CRC 0x00 -> 0x09, card state unchanged; without macro -> 0x01.

Source files
------------

// File: rtl/sd_model_pkg.sv
// sd_model_pkg: shared definitions for the SPI-mode SD card model.
//   - command index constants (CMD0..CMD58)
//   - R1 bit positions and an R1 assembly helper
//   - OCR value returned by CMD58, data start token, fill byte
//   - FSM state enum used by sd_card_spi_model
//   - crc7_frame: CRC7 (x^7 + x^3 + 1) over the first five bytes of a frame
// Configuration macro: SD_MODEL_CRC_CHECK_EN (consumed by sd_card_spi_model).
package sd_model_pkg;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD8  = 6'd8;
  localparam logic [5:0] CMD17 = 6'd17;
  localparam logic [5:0] CMD41 = 6'd41;
  localparam logic [5:0] CMD55 = 6'd55;
  localparam logic [5:0] CMD58 = 6'd58;

  localparam int R1_IDLE_BIT    = 0;
  localparam int R1_ILLEGAL_BIT = 2;
  localparam int R1_CRC_BIT     = 3;
  localparam int R1_PARAM_BIT   = 6;

  localparam logic [31:0] OCR_VALUE  = 32'hC0FF_8000;
  localparam logic [7:0]  DATA_TOKEN = 8'hFE;
  localparam logic [7:0]  FILL_BYTE  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RX,
    ST_NCR,
    ST_RESP,
    ST_NAC,
    ST_TOKEN,
    ST_DATA,
    ST_CRC
  } sd_state_e;

  function automatic logic [7:0] r1_byte(input logic idle, input logic illegal,
                                         input logic crc_err, input logic param_err);
    logic [7:0] r;
    r = 8'h00;
    r[R1_IDLE_BIT]    = idle;
    r[R1_ILLEGAL_BIT] = illegal;
    r[R1_CRC_BIT]     = crc_err;
    r[R1_PARAM_BIT]   = param_err;
    return r;
  endfunction

  // Bit-serial CRC7, MSB first, as transmitted on the wire.
  function automatic logic [6:0] crc7_frame(input logic [39:0] msg);
    logic [6:0] crc;
    logic       fb;
    crc = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb  = crc[6] ^ msg[i];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

endpackage

// File: rtl/sd_spi_byte_if.sv
// sd_spi_byte_if: oversampled SPI mode-0 byte interface on the system clock.
//   clk, rst   : system clock, synchronous active-high reset
//   sclk, cs_n, mosi : asynchronous SPI inputs (2-flop synchronised here)
//   tx_byte, tx_load : next byte to transmit and its one-clk load strobe
//   miso       : card -> host data, 1 while deselected or after reset
//   rx_byte    : last completed received byte (valid with byte_done)
//   byte_done  : one-clk strobe after the 8th rising sclk edge of a byte
//   cs_active  : synchronised chip-select, high while selected
//
// Handshake: byte_done is a one-clk valid strobe with no back-pressure; the
// consumer must answer with tx_load (one clk later is fine) before the next
// falling sclk edge, which then drives tx_byte[7]. If no load arrives, the
// shifter keeps draining and fills with 1s.
module sd_spi_byte_if (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  input  logic [7:0] tx_byte,
  input  logic       tx_load,
  output logic       miso,
  output logic [7:0] rx_byte,
  output logic       byte_done,
  output logic       cs_active
);

  logic [1:0] sclk_sync;
  logic [1:0] cs_sync;
  logic [1:0] mosi_sync;
  logic       sclk_q;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic       sclk_rise;
  logic       sclk_fall;

  assign sclk_rise = sclk_sync[1] & ~sclk_q;
  assign sclk_fall = ~sclk_sync[1] & sclk_q;
  assign cs_active = ~cs_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      mosi_sync <= 2'b11;
      sclk_q    <= 1'b0;
      bit_cnt   <= 3'd0;
      rx_shift  <= 7'd0;
      tx_shift  <= 8'hFF;
      miso      <= 1'b1;
      rx_byte   <= 8'h00;
      byte_done <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_q    <= sclk_sync[1];
      byte_done <= 1'b0;
      if (cs_sync[1]) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'hFF;
        miso     <= 1'b1;
      end else begin
        if (sclk_rise) begin
          rx_shift <= {rx_shift[5:0], mosi_sync[1]};
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_done <= 1'b1;
            rx_byte   <= {rx_shift, mosi_sync[1]};
          end
        end
        // The load lands between the 8th rising edge and the following
        // falling edge, so both never coincide at the supported ratios.
        if (tx_load) begin
          tx_shift <= tx_byte;
        end else if (sclk_fall) begin
          miso     <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b1};
        end
      end
    end
  end

endmodule

// File: rtl/sd_card_spi_model.sv
// sd_card_spi_model: SPI-mode SD card behavioural model.
// Decodes 6-byte command frames and answers CMD0/8/55/ACMD41/58/17 with
// R1/R3/R7 responses; CMD17 streams one block from a computed read-only memory
// where byte i of block b is (b*BLOCK_SIZE + i) mod 256.
//   clk, rst  : system clock (>= 8x sclk), synchronous active-high reset
//   sclk, cs_n, mosi, miso : SPI mode-0 slave pins
//   card_idle : R1 idle bit, 1 until ACMD41 completes
//   cmd_valid : one-clk pulse when a full command frame is accepted
//   cmd_index : index of the last accepted command
// Configuration macro: SD_MODEL_CRC_CHECK_EN -- when defined, byte 5 must be
// {CRC7(bytes 0..4), 1}; a mismatch answers crc_err and skips the command.
import sd_model_pkg::*;

module sd_card_spi_model #(
  parameter int BLOCK_SIZE     = 512,
  parameter int MEM_BLOCKS     = 4,
  parameter int NCR_BYTES      = 1,
  parameter int NAC_BYTES      = 2,
  parameter int ACMD41_RETRIES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       card_idle,
  output logic       cmd_valid,
  output logic [5:0] cmd_index
);

  localparam int          ADDR_W       = $clog2(BLOCK_SIZE);
  localparam logic [3:0]  NCR_LAST     = 4'(NCR_BYTES - 1);
  localparam logic [3:0]  NAC_LAST     = 4'(NAC_BYTES - 1);
  localparam logic [3:0]  RETRY_MAX    = 4'(ACMD41_RETRIES);
  localparam logic [31:0] MEM_BLOCKS_L = 32'(MEM_BLOCKS);

  sd_state_e         state;
  logic [5:0]        cmd_idx_r;
  logic [31:0]       arg_sr;
  logic [2:0]        frame_cnt;
  logic [3:0]        gap_cnt;
  logic [39:0]       resp_sr;
  logic [3:0]        resp_last;
  logic              data_pending;
  logic [7:0]        blk_lo;
  logic [ADDR_W-1:0] data_addr;
  logic              app_cmd;
  logic [3:0]        retry_cnt;

  logic [7:0] tx_byte;
  logic       tx_load;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       cs_active;

  sd_spi_byte_if u_byte_if (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .tx_byte   (tx_byte),
    .tx_load   (tx_load),
    .miso      (miso),
    .rx_byte   (rx_byte),
    .byte_done (byte_done),
    .cs_active (cs_active)
  );

  // Frame byte 0 always carries 2'b01 above the index, so it is rebuilt here
  // rather than stored.
  logic crc_ok;
`ifdef SD_MODEL_CRC_CHECK_EN
  assign crc_ok = (rx_byte == {crc7_frame({2'b01, cmd_idx_r, arg_sr}), 1'b1});
`else
  assign crc_ok = 1'b1;
`endif

  // Outcome of the frame being completed by the current rx_byte.
  logic        ex_idle;
  logic        ex_app;
  logic [3:0]  ex_retry;
  logic        ex_illegal;
  logic        ex_crc;
  logic        ex_param;
  logic        ex_data;
  logic [3:0]  ex_last;
  logic [31:0] ex_tail;
  logic [7:0]  ex_r1;

  always_comb begin
    ex_idle    = card_idle;
    ex_app     = 1'b0;
    ex_retry   = retry_cnt;
    ex_illegal = 1'b0;
    ex_crc     = 1'b0;
    ex_param   = 1'b0;
    ex_data    = 1'b0;
    ex_last    = 4'd0;
    ex_tail    = 32'hFFFF_FFFF;
    if (!crc_ok) begin
      ex_crc = 1'b1;
    end else begin
      case (cmd_idx_r)
        CMD0: begin
          ex_idle  = 1'b1;
          ex_retry = 4'd0;
        end
        CMD8: begin
          ex_last = 4'd4;
          ex_tail = {24'h00_0001, arg_sr[7:0]};
        end
        CMD55: ex_app = 1'b1;
        CMD41: begin
          if (!app_cmd) ex_illegal = 1'b1;
          else if (retry_cnt < RETRY_MAX) ex_retry = retry_cnt + 4'd1;
          else ex_idle = 1'b0;
        end
        CMD58: begin
          ex_last = 4'd4;
          ex_tail = OCR_VALUE;
        end
        CMD17: begin
          if (card_idle) ex_illegal = 1'b1;
          else if (arg_sr >= MEM_BLOCKS_L) ex_param = 1'b1;
          else ex_data = 1'b1;
        end
        default: ex_illegal = 1'b1;
      endcase
    end
    // R1 reports the idle state after the command has taken effect.
    ex_r1 = r1_byte(ex_idle, ex_illegal, ex_crc, ex_param);
  end

  logic [7:0] data_first;
  logic [7:0] data_next;
  assign data_first = 8'(16'(blk_lo) * 16'(BLOCK_SIZE));
  assign data_next  = 8'(16'(blk_lo) * 16'(BLOCK_SIZE) + 16'(data_addr) + 16'd1);

  // On every byte_done the FSM picks the byte for the next slot; tx_load hands
  // it to the shifter one clk later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cmd_idx_r    <= 6'd0;
      arg_sr       <= 32'd0;
      frame_cnt    <= 3'd0;
      gap_cnt      <= 4'd0;
      resp_sr      <= {5{FILL_BYTE}};
      resp_last    <= 4'd0;
      data_pending <= 1'b0;
      blk_lo       <= 8'd0;
      data_addr    <= '0;
      app_cmd      <= 1'b0;
      retry_cnt    <= 4'd0;
      card_idle    <= 1'b1;
      cmd_valid    <= 1'b0;
      cmd_index    <= 6'd0;
      tx_byte      <= FILL_BYTE;
      tx_load      <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      tx_load   <= 1'b0;
      if (!cs_active) begin
        // Deselect aborts the transaction; card state is kept.
        state        <= ST_IDLE;
        frame_cnt    <= 3'd0;
        gap_cnt      <= 4'd0;
        data_pending <= 1'b0;
        tx_byte      <= FILL_BYTE;
      end else if (byte_done) begin
        tx_load <= 1'b1;
        tx_byte <= FILL_BYTE;
        case (state)
          ST_IDLE: begin
            if (rx_byte[7:6] == 2'b01) begin
              cmd_idx_r <= rx_byte[5:0];
              frame_cnt <= 3'd1;
              state     <= ST_CMD_RX;
            end
          end
          ST_CMD_RX: begin
            if (frame_cnt == 3'd5) begin
              cmd_valid    <= 1'b1;
              cmd_index    <= cmd_idx_r;
              card_idle    <= ex_idle;
              app_cmd      <= ex_app;
              retry_cnt    <= ex_retry;
              resp_sr      <= {ex_r1, ex_tail};
              resp_last    <= ex_last;
              data_pending <= ex_data;
              blk_lo       <= arg_sr[7:0];
              gap_cnt      <= 4'd0;
              frame_cnt    <= 3'd0;
              state        <= ST_NCR;
            end else begin
              arg_sr    <= {arg_sr[23:0], rx_byte};
              frame_cnt <= frame_cnt + 3'd1;
            end
          end
          ST_NCR: begin
            if (gap_cnt == NCR_LAST) begin
              gap_cnt <= 4'd0;
              tx_byte <= resp_sr[39:32];
              state   <= ST_RESP;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          ST_RESP: begin
            if (gap_cnt == resp_last) begin
              gap_cnt <= 4'd0;
              state   <= data_pending ? ST_NAC : ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
              resp_sr <= {resp_sr[31:0], FILL_BYTE};
              tx_byte <= resp_sr[31:24];
            end
          end
          ST_NAC: begin
            if (gap_cnt == NAC_LAST) begin
              gap_cnt <= 4'd0;
              tx_byte <= DATA_TOKEN;
              state   <= ST_TOKEN;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          ST_TOKEN: begin
            data_addr <= '0;
            tx_byte   <= data_first;
            state     <= ST_DATA;
          end
          ST_DATA: begin
            // BLOCK_SIZE is a power of two, so all-ones marks the last byte.
            if (&data_addr) begin
              gap_cnt <= 4'd0;
              state   <= ST_CRC;
            end else begin
              data_addr <= data_addr + 1'b1;
              tx_byte   <= data_next;
            end
          end
          ST_CRC: begin
            if (gap_cnt == 4'd1) begin
              gap_cnt      <= 4'd0;
              data_pending <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_card_spi_model.sv
// tb_sd_card_spi_model: bench for sd_card_spi_model (BLOCK_SIZE=16).
// A host SPI driver clocks whole command transactions; a reference model of
// the card (state variables plus response rules) predicts every miso byte and
// every accepted command index, pushed into expected queues. Independent
// monitors pop and compare as bytes complete on the wire and as cmd_valid fires.
module tb_sd_card_spi_model;

  localparam int BS   = 16;
  localparam int MB   = 4;
  localparam int NCR  = 1;
  localparam int NAC  = 2;
  localparam int RET  = 2;
  localparam int HALF = 6;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic       card_idle;
  logic       cmd_valid;
  logic [5:0] cmd_index;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] exp_q[$];
  logic [5:0] exp_cmd_q[$];
  logic [7:0] seq[$];

  // Reference card state.
  logic m_idle  = 1'b1;
  logic m_app   = 1'b0;
  int   m_retry = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sd_card_spi_model #(
    .BLOCK_SIZE     (BS),
    .MEM_BLOCKS     (MB),
    .NCR_BYTES      (NCR),
    .NAC_BYTES      (NAC),
    .ACMD41_RETRIES (RET)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .card_idle (card_idle),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC7 by polynomial long division of the 40-bit message times x^7.
  function automatic logic [7:0] good_crc(input logic [5:0] idx, input logic [31:0] arg);
    logic [46:0] r;
    r = {2'b01, idx, arg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return {r[6:0], 1'b1};
  endfunction

  // ---------------- reference model ----------------
  // Builds the full miso byte stream of one transaction and updates state.
  task automatic build_seq(input logic [5:0] idx, input logic [31:0] arg, input bit crc_bad);
    seq.delete();
    repeat (6 + NCR) seq.push_back(8'hFF);
    if (crc_bad) begin
      m_app = 1'b0;
      seq.push_back(8'h08 | {7'd0, m_idle});
    end else begin
      case (idx)
        6'd0: begin
          m_idle = 1'b1; m_app = 1'b0; m_retry = 0;
          seq.push_back(8'h01);
        end
        6'd8: begin
          m_app = 1'b0;
          seq.push_back({7'd0, m_idle});
          seq.push_back(8'h00); seq.push_back(8'h00); seq.push_back(8'h01);
          seq.push_back(arg[7:0]);
        end
        6'd55: begin
          m_app = 1'b1;
          seq.push_back({7'd0, m_idle});
        end
        6'd41: begin
          if (!m_app) seq.push_back(8'h04 | {7'd0, m_idle});
          else if (m_retry < RET) begin
            m_retry++;
            seq.push_back(8'h01);
          end else begin
            m_idle = 1'b0;
            seq.push_back(8'h00);
          end
          m_app = 1'b0;
        end
        6'd58: begin
          m_app = 1'b0;
          seq.push_back({7'd0, m_idle});
          seq.push_back(8'hC0); seq.push_back(8'hFF); seq.push_back(8'h80); seq.push_back(8'h00);
        end
        6'd17: begin
          m_app = 1'b0;
          if (m_idle) seq.push_back(8'h05);
          else if (arg >= MB) seq.push_back(8'h40);
          else begin
            seq.push_back(8'h00);
            repeat (NAC) seq.push_back(8'hFF);
            seq.push_back(8'hFE);
            for (int i = 0; i < BS; i++) seq.push_back(8'((arg * BS + i) % 256));
            seq.push_back(8'hFF); seq.push_back(8'hFF);
          end
        end
        default: begin
          m_app = 1'b0;
          seq.push_back(8'h04 | {7'd0, m_idle});
        end
      endcase
    end
    seq.push_back(8'hFF);
  endtask

  // ---------------- driver ----------------
  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // limit > 0 truncates the transaction after that many bytes (>= 6).
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                         input int limit, input bit hold_cs);
    logic [7:0] fb[6];
    bit         bad;
    int         n;
    bad = 1'b0;
`ifdef SD_MODEL_CRC_CHECK_EN
    bad = (crc != good_crc(idx, arg));
`endif
    build_seq(idx, arg, bad);
    n = (limit > 0 && limit < seq.size()) ? limit : seq.size();
    for (int k = 0; k < n; k++) exp_q.push_back(seq[k]);
    exp_cmd_q.push_back(idx);
    fb[0] = {2'b01, idx};
    fb[1] = arg[31:24]; fb[2] = arg[23:16]; fb[3] = arg[15:8]; fb[4] = arg[7:0];
    fb[5] = crc;
    cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < n; k++) spi_byte(k < 6 ? fb[k] : 8'hFF);
    mosi = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    if (!hold_cs) begin
      cs_n = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic cmd(input logic [5:0] idx, input logic [31:0] arg);
    run_cmd(idx, arg, good_crc(idx, arg), 0, 1'b0);
    check("card_idle", {31'd0, card_idle}, {31'd0, m_idle});
  endtask

  // ---------------- monitors / scoreboard ----------------
  logic [7:0] mon_sr   = 8'hFF;
  int         mon_bits = 0;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) mon_bits = 0;
    else begin
      mon_sr = {mon_sr[6:0], miso};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL miso_byte: got 0x%0h, expected no byte", mon_sr);
        end else check("miso_byte", {24'd0, mon_sr}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && cmd_valid) begin
      if (exp_cmd_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL cmd_valid: got pulse with index %0d, expected none", cmd_index);
      end else check("cmd_index", {26'd0, cmd_index}, {26'd0, exp_cmd_q.pop_front()});
    end
  end

  initial begin
    #(90000 * 10);
    miscompares++;
    $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int         kind;
    int         limit;
    logic [5:0] idx;
    logic [31:0] arg;

    repeat (5) @(negedge clk);
    check("reset_miso",      {31'd0, miso},      32'd1);
    check("reset_card_idle", {31'd0, card_idle}, 32'd1);
    check("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("reset_cmd_index", {26'd0, cmd_index}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    cmd(6'd0, 32'd0);
    // Bad CRC between CMD55 and CMD41: app must be dropped either way.
    cmd(6'd55, 32'd0);
    run_cmd(6'd0, 32'd0, 8'h00, 0, 1'b0);
    check("crc_card_idle", {31'd0, card_idle}, {31'd0, m_idle});
    cmd(6'd41, 32'h4000_0000);
    cmd(6'd8, 32'h0000_01AA);
    cmd(6'd17, 32'd1);
    for (int i = 0; i < 3; i++) begin
      cmd(6'd55, 32'd0);
      cmd(6'd41, 32'h4000_0000);
    end
    cmd(6'd58, 32'd0);
    cmd(6'd17, 32'd1);
    cmd(6'd17, 32'd4);

    // Deselect in the middle of the data block, then a clean R3.
    run_cmd(6'd17, 32'd3, good_crc(6'd17, 32'd3), 6 + NCR + 1 + NAC + 1 + 7, 1'b0);
    cmd(6'd58, 32'd0);

    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 5);
      arg  = $urandom;
      case (kind)
        0: begin idx = 6'd17; arg = $urandom_range(0, MB + 1); end
        1: idx = 6'd8;
        2: idx = 6'd58;
        3: idx = 6'd55;
        4: idx = 6'd41;
        default: idx = 6'($urandom_range(0, 63));
      endcase
      limit = ($urandom_range(0, 2) == 0) ? 6 + $urandom_range(0, 20) : 0;
      run_cmd(idx, arg, good_crc(idx, arg), limit, 1'b0);
      check("rand_card_idle", {31'd0, card_idle}, {31'd0, m_idle});
    end

    // Make sure the card is ready, then reset in the middle of a data block.
    cmd(6'd55, 32'd0);
    cmd(6'd41, 32'h4000_0000);
    run_cmd(6'd17, 32'd2, good_crc(6'd17, 32'd2), 6 + NCR + 1 + NAC + 1 + 5, 1'b1);
    rst = 1'b1;
    m_idle = 1'b1; m_app = 1'b0; m_retry = 0;
    repeat (2) @(negedge clk);
    check("rst_mid_miso",      {31'd0, miso},      32'd1);
    check("rst_mid_card_idle", {31'd0, card_idle}, 32'd1);
    rst  = 1'b0;
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    cmd(6'd0, 32'd0);
    cmd(6'd58, 32'd0);

    repeat (20) @(negedge clk);
    check("exp_q_drained",   exp_q.size(),     32'd0);
    check("exp_cmd_drained", exp_cmd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
